// File: rtl/ifetch_unit.sv
// Instruction fetch: requests one word at a time, holds it until the controller accepts it, follows branches and flushes.
// Latency: one cycle from request to o_instr_vld with a zero-wait ack. Backpressure: i_instr_rdy low freezes the held instruction.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_rdy,
    input  logic        i_br_sel,
    input  logic [31:0] i_br_addr,
    input  logic        i_flush,
    input  logic [31:0] i_flush_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_vld,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic        o_misalign
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr;
    logic [31:0] instr_q;
    logic        misalign_q, misalign_nxt;
    logic        capture;
    logic        load_req;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        misalign_nxt = 1'b0;
        capture      = 1'b0;
        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (i_flush) begin
                    state_nxt = i_imem_ack ? FETCH : DROP;
                end else if (i_imem_ack) begin
                    state_nxt = HOLD;
                    capture   = 1'b1;
                end
            end
            HOLD: begin
                if (i_flush) begin
                    state_nxt = FETCH;
                end else if (i_instr_rdy) begin
                    state_nxt    = FETCH;
                    pc_nxt       = i_br_sel ? {i_br_addr[31:2], 2'b00} : pc + 32'd4;
                    misalign_nxt = i_br_sel && (i_br_addr[1:0] != 2'b00);
                end
            end
            DROP: begin
                if (i_imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush outranks everything else, including a branch accepted in the same cycle.
        if (i_flush) begin
            pc_nxt       = {i_flush_addr[31:2], 2'b00};
            misalign_nxt = (i_flush_addr[1:0] != 2'b00);
        end
    end

    // A new request address is taken on every entry into FETCH, never while a request is still outstanding.
    assign load_req = (state_nxt == FETCH) && ((state != FETCH) || i_imem_ack);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            instr_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            misalign_q <= misalign_nxt;
            if (load_req) req_addr <= pc_nxt;
            if (capture)  instr_q  <= i_imem_rdata;
        end
    end

    assign o_imem_req  = (state == FETCH) || (state == DROP);
    assign o_imem_addr = req_addr;
    assign o_instr_vld = (state == HOLD);
    assign o_instr     = o_instr_vld ? instr_q : 32'h0;
    assign o_pc        = req_addr;
    assign o_pc_four   = req_addr + 32'd4;
    assign o_misalign  = misalign_q;

endmodule
